// File: rtl/iwm_pkg.sv
// Shared IWM constants for the 50 MHz clock domain.
// Used by the read shifter and the write serializer so both agree on bit-cell
// timing. iwm_cnt_width() sizes a cell timer that must reach 1.5 cells.
package iwm_pkg;

    localparam int unsigned IWM_BIT_CELL_50M   = 200;
    localparam int unsigned IWM_GLITCH_MIN_50M = 50;

    function automatic int unsigned iwm_cnt_width(input int unsigned bit_cell);
        return $clog2(2 * bit_cell);
    endfunction

endpackage

// File: rtl/rddata_sync.sv
// Two-flop synchronizer plus falling-edge detector for an asynchronous drive
// signal (rddata, sense).
// Ports:
//   clk   in  : system clock
//   reset in  : synchronous, active-high
//   din   in  : asynchronous input from the drive connector
//   fall  out : one-clock pulse when the synchronized input goes 1 -> 0
module rddata_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Reset to 0: an idle-high line then reads as a rising edge, never as a
    // spurious falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/iwm_read_shifter.sv
// IWM disk read-path front end.
// Recovers bit cells from the rddata flux-transition stream with a window
// timer and assembles GCR bytes (a byte is complete when a 1 reaches bit 7).
// Ports:
//   clk        in     : 50 MHz system clock
//   reset      in     : synchronous, active-high; clears all state
//   rddata     in     : asynchronous read data; falling edge = flux transition
//   enable     in     : read mode with motor on; low holds timer/shifter clear
//   read_ack   in     : one-clock pulse, CPU consumed data_out
//   data_out   out[8] : last completed byte
//   byte_ready out    : byte latched and not yet acknowledged
//   overrun    out    : sticky, byte completed while byte_ready was still set
//   bit_strobe out    : one-clock pulse per recovered bit
module iwm_read_shifter
    import iwm_pkg::*;
#(
    parameter int unsigned BIT_CELL   = IWM_BIT_CELL_50M,
    parameter int unsigned GLITCH_MIN = IWM_GLITCH_MIN_50M
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rddata,
    input  logic       enable,
    input  logic       read_ack,
    output logic [7:0] data_out,
    output logic       byte_ready,
    output logic       overrun,
    output logic       bit_strobe
);

    localparam int unsigned CW = iwm_cnt_width(BIT_CELL);
    localparam logic [CW-1:0] TIMEOUT = CW'(BIT_CELL + BIT_CELL / 2 - 1);
    localparam logic [CW-1:0] RECENTRE = CW'(BIT_CELL / 2);
    localparam logic [CW-1:0] GMIN = CW'(GLITCH_MIN);

    logic          fall;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic          accept;
    logic          timeout;
    logic          emit;
    logic [7:0]    nxt;

    rddata_sync u_rddata_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rddata),
        .fall  (fall)
    );

    // An accepted edge is a 1; a timeout with no edge is a 0. Edges closer
    // than GLITCH_MIN to the previous accepted one fall through to counting.
    always_comb begin
        accept  = fall & (cnt >= GMIN);
        timeout = (cnt == TIMEOUT);
        emit    = enable & (accept | timeout);
        nxt     = {shreg[6:0], accept};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            byte_ready <= 1'b0;
            overrun    <= 1'b0;
            bit_strobe <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            shreg      <= '0;
            byte_ready <= 1'b0;
            overrun    <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= emit;

            if (accept)
                cnt <= '0;
            else if (timeout)
                cnt <= RECENTRE;   // next zero lands one full cell later
            else
                cnt <= cnt + 1'b1;

            if (read_ack)
                byte_ready <= 1'b0;

            // Completion overrides a same-cycle read_ack: the new byte wins.
            if (emit) begin
                if (nxt[7]) begin
                    data_out   <= nxt;
                    shreg      <= '0;
                    byte_ready <= 1'b1;
                    if (byte_ready && !read_ack)
                        overrun <= 1'b1;
                end else begin
                    shreg <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_iwm_read_shifter.sv
module tb_iwm_read_shifter;

    logic       clk = 1'b0;
    logic       reset;
    logic       rddata;
    logic       enable;
    logic       read_ack;
    logic [7:0] data_out;
    logic       byte_ready;
    logic       overrun;
    logic       bit_strobe;

    always #10 clk = ~clk;

    iwm_read_shifter #(.BIT_CELL(200), .GLITCH_MIN(50)) dut (
        .clk        (clk),
        .reset      (reset),
        .rddata     (rddata),
        .enable     (enable),
        .read_ack   (read_ack),
        .data_out   (data_out),
        .byte_ready (byte_ready),
        .overrun    (overrun),
        .bit_strobe (bit_strobe)
    );

    int checks = 0;
    int errors = 0;

    // Strobe counter plus a snapshot of the outputs on a chosen strobe.
    int         strobe_cnt = 0;
    int         snap_idx   = -1;
    logic [7:0] snap_data  = '0;
    logic       snap_ready = 1'b0;

    always @(negedge clk) begin
        if (bit_strobe) begin
            if (strobe_cnt == snap_idx) begin
                snap_data  <= data_out;
                snap_ready <= byte_ready;
            end
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] b;
        int         c0;
        int         c1;
        bit         glitch;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks; drive and sample 1 ns after the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic fresh();
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(100);
    endtask

    // Send the top nbits of b, MSB first, cells alternating c0/c1 clocks.
    task automatic send(input logic [7:0] b, input int c0, input int c1,
                        input int nbits, input bit glitch, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            int len;
            len = (i % 2 == 0) ? c0 : c1;
            if (b[7-i]) begin
                rddata = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    tick(1);
                    read_ack = ack_last && (i == nbits - 1) && (j == 1);
                end
                rddata = 1'b1;
                if (glitch && i == 0) begin
                    tick(26);
                    rddata = 1'b0;
                    tick(4);
                    rddata = 1'b1;
                    tick(len - 34);
                end else begin
                    tick(len - 4);
                end
            end else begin
                tick(len);
            end
        end
    endtask

    task automatic send_byte_checked(input string name, input logic [7:0] b,
                                     input int c0, input int c1, input bit glitch,
                                     input logic [7:0] exp);
        int base;
        base     = strobe_cnt;
        snap_idx = strobe_cnt + 7;
        send(b, c0, c1, 8, glitch, 1'b0);
        for (int k = 0; k < 400 && strobe_cnt < base + 8; k++) tick(1);
        check({name, " strobes"}, strobe_cnt - base, 8);
        check({name, " ready@8th"}, snap_ready, 1);
        check({name, " data@8th"}, snap_data, exp);
        check({name, " data_out"}, data_out, exp);
        check({name, " byte_ready"}, byte_ready, 1);
    endtask

    initial begin
        int gap;

        vecs[0] = '{8'hD5, 200, 200, 1'b0, 8'hD5};
        vecs[1] = '{8'hFF, 200, 200, 1'b0, 8'hFF};
        vecs[2] = '{8'h80, 200, 200, 1'b0, 8'h80};
        vecs[3] = '{8'h96, 200, 200, 1'b1, 8'h96};
        vecs[4] = '{8'hD5, 170, 230, 1'b0, 8'hD5};
        vecs[5] = '{8'hDE, 200, 200, 1'b0, 8'hDE};
        vecs[6] = '{8'hAA, 200, 200, 1'b0, 8'hAA};
        vecs[7] = '{8'h96, 150, 250, 1'b0, 8'h96};

        reset    = 1'b1;
        rddata   = 1'b1;
        enable   = 1'b0;
        read_ack = 1'b0;
        tick(3);
        check("reset data_out", data_out, 0);
        check("reset byte_ready", byte_ready, 0);
        check("reset overrun", overrun, 0);
        check("reset bit_strobe", bit_strobe, 0);
        reset = 1'b0;
        tick(1);

        // Table-driven single bytes from a freshly enabled timer.
        for (int v = 0; v < 8; v++) begin
            fresh();
            send_byte_checked($sformatf("vec%0d", v), vecs[v].b, vecs[v].c0,
                              vecs[v].c1, vecs[v].glitch, vecs[v].exp);
            check($sformatf("vec%0d overrun", v), overrun, 0);
        end

        // read_ack clears byte_ready on the next edge, data_out holds.
        read_ack = 1'b1;
        tick(1);
        read_ack = 1'b0;
        check("ack byte_ready", byte_ready, 0);
        check("ack data_out", data_out, 8'h96);

        // Sync zeros: first at 300 clocks after enable, then every 200.
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        for (int z = 0; z < 10; z++) begin
            gap = 0;
            do begin
                tick(1);
                gap++;
            end while (!bit_strobe && gap < 400);
            check($sformatf("zero%0d gap", z), gap, (z == 0) ? 300 : 200);
            check($sformatf("zero%0d shreg", z), dut.shreg, 0);
            check($sformatf("zero%0d byte_ready", z), byte_ready, 0);
        end
        send_byte_checked("sync FF", 8'hFF, 200, 200, 1'b0, 8'hFF);

        // Overrun: $AA then $AB with no acknowledge.
        fresh();
        send_byte_checked("ovr AA", 8'hAA, 200, 200, 1'b0, 8'hAA);
        check("ovr AA overrun", overrun, 0);
        send_byte_checked("ovr AB", 8'hAB, 200, 200, 1'b0, 8'hAB);
        check("ovr AB overrun", overrun, 1);

        // Acknowledge on the exact completion clock of $AB: no overrun.
        fresh();
        check("enable clears overrun", overrun, 0);
        send_byte_checked("ack AA", 8'hAA, 200, 200, 1'b0, 8'hAA);
        send(8'hAB, 200, 200, 8, 1'b0, 1'b1);
        check("ackcmp data_out", data_out, 8'hAB);
        check("ackcmp byte_ready", byte_ready, 1);
        check("ackcmp overrun", overrun, 0);

        // Reset after 4 bits of $DE, then a full $DE.
        send(8'hDE, 200, 200, 4, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst data_out", data_out, 0);
        check("midrst byte_ready", byte_ready, 0);
        check("midrst overrun", overrun, 0);
        check("midrst bit_strobe", bit_strobe, 0);
        tick(100);
        send_byte_checked("rst DE", 8'hDE, 200, 200, 1'b0, 8'hDE);

        // Enable pulse low after 4 bits of $DE with overrun pending.
        fresh();
        send(8'hAA, 200, 200, 8, 1'b0, 1'b0);
        send(8'hAB, 200, 200, 8, 1'b0, 1'b0);
        check("en pre overrun", overrun, 1);
        send(8'hDE, 200, 200, 4, 1'b0, 1'b0);
        enable = 1'b0;
        tick(1);
        check("en low byte_ready", byte_ready, 0);
        check("en low overrun", overrun, 0);
        check("en low data_out", data_out, 8'hAB);
        enable = 1'b1;
        tick(100);
        check("en held data_out", data_out, 8'hAB);
        send_byte_checked("en DE", 8'hDE, 200, 200, 1'b0, 8'hDE);
        check("en DE overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
